// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and fetch request sequencing, instruction latch and
// field split for the control decoder, with stall, redirect and HALT handling.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [3:0]         opcode,
    output logic [1:0]         format,
    output logic               imm_flag,
    output logic [1:0]         operand,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

    localparam logic [3:0] OP_HALT = 4'b1110;

    state_t             state_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic [PC_W-1:0]    pc_out_reg;
    logic               imem_req_reg;
    logic               instr_valid_reg;
    logic               halted_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            ir_reg          <= '0;
            pc_out_reg      <= '0;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        pc_reg       <= '0;
                        imem_req_reg <= 1'b1;
                        state_reg    <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        ir_reg          <= imem_data;
                        pc_out_reg      <= pc_reg;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A stalled instruction holds everything, including any redirect.
                    if (!stall) begin
                        instr_valid_reg <= 1'b0;
                        if (ir_reg[8:5] == OP_HALT) begin
                            halted_reg <= 1'b1;
                            state_reg  <= HALTED;
                        end else begin
                            pc_reg       <= redirect_valid ? redirect_pc : pc_reg + 1'b1;
                            imem_req_reg <= 1'b1;
                            state_reg    <= FETCH;
                        end
                    end
                end
                default: begin
                    // HALTED is terminal until reset.
                    state_reg <= HALTED;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign instr_valid = instr_valid_reg;
    assign opcode      = ir_reg[8:5];
    assign format      = ir_reg[4:3];
    assign imm_flag    = ir_reg[2];
    assign operand     = ir_reg[1:0];
    assign pc_out      = pc_out_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a transaction-level model
// that tracks the expected PC and the fields of each issued instruction.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [8:0] imem_data;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [1:0] format;
    logic       imm_flag;
    logic [1:0] operand;
    logic [7:0] pc_out;
    logic       halted;

    int errors = 0;
    int checks = 0;
    int model_pc = 0;

    fetch_unit #(.PC_W(8), .INSTR_W(9)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .opcode(opcode), .format(format),
        .imm_flag(imm_flag), .operand(operand), .pc_out(pc_out), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag, input logic [8:0] word, input int pc);
        check({tag, ".valid"},    32'(instr_valid), 32'd1);
        check({tag, ".opcode"},   32'(opcode),      32'(word[8:5]));
        check({tag, ".format"},   32'(format),      32'(word[4:3]));
        check({tag, ".imm_flag"}, 32'(imm_flag),    32'(word[2]));
        check({tag, ".operand"},  32'(operand),     32'(word[1:0]));
        check({tag, ".pc_out"},   32'(pc_out),      32'(pc));
        check({tag, ".req"},      32'(imem_req),    32'd0);
    endtask

    // Assumes the DUT is in FETCH at model_pc. Serves one word after lat cycles,
    // stalls it, then accepts it with an optional redirect.
    task automatic fetch_issue(input logic [8:0] word, input int lat, input int stalls,
                               input bit redir, input logic [7:0] rpc);
        int issue_pc;
        issue_pc = model_pc;
        for (int i = 0; i < lat - 1; i++) begin
            check("wait.req",   32'(imem_req),    32'd1);
            check("wait.addr",  32'(imem_addr),   32'(model_pc));
            check("wait.valid", 32'(instr_valid), 32'd0);
            imem_valid     = 1'b0;
            imem_data      = 9'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc    = 8'($urandom);
            start          = 1'($urandom);
            step();
        end
        check("fetch.req",  32'(imem_req),  32'd1);
        check("fetch.addr", 32'(imem_addr), 32'(model_pc));
        imem_valid     = 1'b1;
        imem_data      = word;
        redirect_valid = 1'b0;
        start          = 1'b0;
        step();
        imem_valid = 1'b0;
        check_fields("issue", word, issue_pc);
        for (int s = 0; s < stalls; s++) begin
            stall          = 1'b1;
            redirect_valid = 1'($urandom);
            redirect_pc    = 8'($urandom);
            imem_valid     = 1'($urandom);
            imem_data      = 9'($urandom);
            step();
            check_fields("stall", word, issue_pc);
            check("stall.addr", 32'(imem_addr), 32'(model_pc));
        end
        stall          = 1'b0;
        imem_valid     = 1'b0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        step();
        redirect_valid = 1'b0;
        if (word[8:5] == 4'b1110) begin
            check("halt.halted", 32'(halted),      32'd1);
            check("halt.valid",  32'(instr_valid), 32'd0);
            check("halt.req",    32'(imem_req),    32'd0);
        end else begin
            model_pc = redir ? int'(rpc) : (model_pc + 1) % 256;
            check("next.req",   32'(imem_req),    32'd1);
            check("next.addr",  32'(imem_addr),   32'(model_pc));
            check("next.valid", 32'(instr_valid), 32'd0);
        end
        $display("txn word=%03h pc=%02h lat=%0d stalls=%0d redir=%0d next_pc=%02h",
                 word, issue_pc, lat, stalls, redir, model_pc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_pc = 0;
        check("rst.valid",  32'(instr_valid), 32'd0);
        check("rst.req",    32'(imem_req),    32'd0);
        check("rst.halted", 32'(halted),      32'd0);
        check("rst.opcode", 32'({opcode, format, imm_flag, operand}), 32'd0);
        check("rst.pc_out", 32'(pc_out),      32'd0);
        check("rst.addr",   32'(imem_addr),   32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start.req",  32'(imem_req),  32'd1);
        check("start.addr", 32'(imem_addr), 32'd0);
    endtask

    initial begin
        logic [8:0] w;
        reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        do_reset();
        step();
        check("idle.req", 32'(imem_req), 32'd0);
        do_start();

        fetch_issue(9'b0111_00_0_01, 1, 0, 1'b0, 8'h00);
        fetch_issue(9'b0010_10_1_11, 2, 3, 1'b0, 8'h00);
        fetch_issue(9'b0101_01_0_10, 1, 2, 1'b1, 8'h2A);
        fetch_issue(9'b0001_11_1_00, 3, 0, 1'b1, 8'hFF);
        fetch_issue(9'b1000_01_1_01, 1, 1, 1'b0, 8'h00);

        for (int t = 0; t < 40; t++) begin
            w = 9'($urandom);
            if (w[8:5] == 4'b1110) w[8:5] = 4'b0110;
            fetch_issue(w, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                        1'($urandom), 8'($urandom));
        end

        fetch_issue(9'b1110_00_0_00, 2, 1, 1'b1, 8'h55);
        for (int c = 0; c < 10; c++) begin
            start          = 1'b1;
            redirect_valid = 1'b1;
            imem_valid     = 1'b1;
            step();
            check("halted.req",    32'(imem_req),    32'd0);
            check("halted.valid",  32'(instr_valid), 32'd0);
            check("halted.halted", 32'(halted),      32'd1);
        end
        start = 1'b0; redirect_valid = 1'b0; imem_valid = 1'b0;
        do_reset();
        step();
        check("post_halt.idle", 32'(imem_req), 32'd0);

        do_start();
        fetch_issue(9'b0011_01_0_11, 1, 0, 1'b1, 8'h77);
        reset      = 1'b1;
        imem_valid = 1'b1;
        imem_data  = 9'b0100_11_1_10;
        step();
        reset      = 1'b0;
        imem_valid = 1'b0;
        model_pc   = 0;
        check("midrst.valid", 32'(instr_valid), 32'd0);
        check("midrst.req",   32'(imem_req),    32'd0);
        check("midrst.addr",  32'(imem_addr),   32'd0);
        check("midrst.ir",    32'({opcode, format, imm_flag, operand}), 32'd0);
        check("midrst.pc_out", 32'(pc_out),     32'd0);
        step();
        check("midrst.idle", 32'(imem_req), 32'd0);
        do_start();
        fetch_issue(9'b1001_00_1_01, 2, 0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
